// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Holds the PC, drives the word address to a memory with one cycle of read
// latency, and hands fetched words to the decoder through a 2-entry buffer
// on a valid/ready handshake. Handles single-cycle redirects and stops
// fetching once a HALT opcode has been captured.
// MEM_DEPTH is expected to be a power of two: redirect targets are reduced
// to the PC width by truncation.
module fetch_unit #(
  parameter int         RESET_PC    = 0,
  parameter int         MEM_DEPTH   = 1024,
  parameter logic [7:0] HALT_OPCODE = 8'h0F
) (
  input  logic        CLK,
  input  logic        RESET_N,
  output logic [31:0] ADDRESS,
  input  logic [31:0] INST,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT_INST,
  output logic [31:0] OUT_PC,
  output logic        HALTED
);

  localparam int            AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [AW-1:0] PC_LAST = AW'(MEM_DEPTH - 1);
  localparam logic [AW-1:0] PC_INIT = AW'(RESET_PC);

  // Fetch pointer and the single outstanding memory request
  logic [AW-1:0] pc;
  logic          inflight_q;
  logic [AW-1:0] inflight_pc_q;

  // Two-slot ring buffer of fetched {inst, pc}
  logic [31:0]   fifo_inst [2];
  logic [AW-1:0] fifo_pc   [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    count;

  logic          stop;
  logic          halted_q;

  logic          pop;
  logic          push;
  logic          push_halt;
  logic          pop_halt;
  logic          issue;
  logic [2:0]    occupancy;
  logic [AW-1:0] pc_inc;
  logic          unused_target_bits;

  assign unused_target_bits = ^BRANCH_TARGET[31:AW];

  assign ADDRESS   = 32'(pc);
  assign OUT_VALID = (count != 2'd0);
  assign OUT_INST  = OUT_VALID ? fifo_inst[rd_ptr] : 32'd0;
  assign OUT_PC    = OUT_VALID ? 32'(fifo_pc[rd_ptr]) : 32'd0;
  assign HALTED    = halted_q;

  // A redirect discards this cycle's handshake and the returning word.
  assign pop       = OUT_VALID & OUT_READY & ~BRANCH_TAKEN;
  assign push      = inflight_q & ~BRANCH_TAKEN;
  assign push_halt = push & (INST[31:24] == HALT_OPCODE);
  assign pop_halt  = pop & (OUT_INST[31:24] == HALT_OPCODE);

  // Buffered plus in-flight words after this cycle's pop; a new request is
  // only made while that leaves room, so the buffer can never overflow.
  assign occupancy = 3'(count) + 3'(inflight_q) - 3'(pop);
  assign issue     = ~stop & ~BRANCH_TAKEN & (occupancy < 3'd2);
  assign pc_inc    = (pc == PC_LAST) ? '0 : pc + AW'(1);

  // PC, request tracking, buffer occupancy and halt state
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pc            <= PC_INIT;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      count         <= 2'd0;
      stop          <= 1'b0;
      halted_q      <= 1'b0;
    end else if (BRANCH_TAKEN) begin
      pc         <= BRANCH_TARGET[AW-1:0];
      inflight_q <= 1'b0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
      stop       <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      if (issue) begin
        pc            <= pc_inc;
        inflight_pc_q <= pc;
      end
      // A request made in the cycle the HALT arrives is dropped.
      inflight_q <= issue & ~push_halt;
      if (push_halt) stop <= 1'b1;
      if (pop_halt) halted_q <= 1'b1;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Buffer storage: write the returning word into the tail slot
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < 2; i++) begin
        fifo_inst[i] <= 32'd0;
        fifo_pc[i]   <= '0;
      end
    end else if (push) begin
      fifo_inst[wr_ptr] <= INST;
      fifo_pc[wr_ptr]   <= inflight_pc_q;
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the instruction memory and directly downstream of nothing but the branch-resolution logic. Holds the program counter and drives the memory's word-indexed `ADDRESS` every cycle. Captures the memory's registered `INST` one cycle later. Delivers instructions to the decoder over a valid/ready handshake, using a 2-entry buffer so that decoder backpressure never drops or duplicates an instruction. Also handles branch/jump redirects and stops fetching on the HALT opcode.

## Interface
- `RESET_PC`, 0: PC value loaded on reset (word index).
- `MEM_DEPTH`, 1024: instruction memory depth in words; the PC wraps modulo this value.
- `HALT_OPCODE`, 8'h0F: value of `INST[31:24]` that marks HALT.
- `CLK` input 1: single clock; all state updates on the rising edge.
- `RESET_N` input 1: asynchronous, active-low reset.
- `ADDRESS` output 32: word address to the instruction memory, equal to the PC; bits above log2(MEM_DEPTH) are 0.
- `INST` input 32: instruction word from memory, valid for the address presented one cycle earlier.
- `BRANCH_TAKEN` input 1: single-cycle redirect request from execute.
- `BRANCH_TARGET` input 32: redirect word address, truncated to log2(MEM_DEPTH) bits.
- `OUT_VALID` output 1: buffer head holds an instruction for the decoder.
- `OUT_READY` input 1: decoder accepts the head this cycle.
- `OUT_INST` output 32: head instruction; 0 when `OUT_VALID`=0.
- `OUT_PC` output 32: word address of the head instruction; 0 when `OUT_VALID`=0.
- `HALTED` output 1: HALT instruction has been accepted by the decoder.

## Operation
- **State:**
  - `pc`
  - `inflight_q`: a request was issued last cycle
  - `inflight_pc_q`
  - 2-entry FIFO of {inst, pc} with `count` 0..2
  - `stop`: HALT seen, fetching stopped
  - `halted_q`
- **pop** = `OUT_VALID & OUT_READY`.
- **push** = `inflight_q` and no redirect this cycle. It writes {`INST`, `inflight_pc_q`} into the FIFO.
- **issue** = `!stop & !BRANCH_TAKEN & (count + inflight_q - pop + push_is_halt?0:0) < 2`. The occupancy check uses `count + inflight_q - pop`. Issue marks the current `ADDRESS` as a real request:
  - `inflight_q` <= 1
  - `inflight_pc_q` <= `pc`
  - `pc` <= (`pc`+1) mod MEM_DEPTH
- **No issue:** `pc` holds and `inflight_q` <= 0. Memory re-reads the same word, and that result is ignored.
- **HALT:** when a pushed `INST[31:24]` == `HALT_OPCODE`:
  - `stop` <= 1.
  - Any request issued in that same cycle is squashed (`inflight_q` <= 0).
  - The HALT itself is pushed normally.
- **HALTED:** `halted_q` <= 1 on the cycle the HALT entry is popped. While `stop`=1, no further issue.
- **Redirect (`BRANCH_TAKEN`=1)** has the highest priority:
  - FIFO is flushed (`count` <= 0).
  - `inflight_q` <= 0.
  - `pc` <= `BRANCH_TARGET` mod MEM_DEPTH.
  - `stop` <= 0 and `halted_q` <= 0.
  - No push and no pop are recorded that cycle, even if `OUT_READY`=1.
- FIFO push and pop in the same cycle are both honoured; `count` is unchanged.

## Timing
- **Reset (async, immediate on `RESET_N`=0):**
  - `pc`=`RESET_PC`, so `ADDRESS`=`RESET_PC`
  - `count`=0, `inflight_q`=0, `stop`=0
  - `OUT_VALID`=0, `OUT_INST`=0, `OUT_PC`=0, `HALTED`=0
- **Latency:** `ADDRESS`=A presented in cycle n → `INST` in cycle n+1 → pushed at the end of n+1 → `OUT_VALID` with `OUT_PC`=A in cycle n+2.
- **Throughput:** one instruction per cycle with `OUT_READY` held high. At most 2 instructions are buffered or in flight, so no overflow is possible.
- **Backpressure:** `OUT_INST`/`OUT_PC` are held stable while `OUT_VALID`=1 and `OUT_READY`=0.
- **Redirect:** asserted in cycle n → `ADDRESS`=target in cycle n+1 → first `OUT_VALID` for the target in cycle n+3. `OUT_VALID`=0 in cycles n+1 and n+2.
- **PC wrap:** PC = MEM_DEPTH-1 is followed by 0.
- **Reset mid-operation:** all buffered and in-flight instructions are discarded. Fetch restarts at `RESET_PC` after `RESET_N` rises.

## Test plan
- **Straight-line fetch.** Release reset with `OUT_READY`=1 and memory words 0–2 = 02000000, 02010001, 0402000A. Required: `ADDRESS` counts 0,1,2,… each cycle; `OUT_VALID` first high 2 cycles after reset release with `OUT_PC`=0, `OUT_INST`=02000000; then one instruction per cycle in order.
- **Backpressure.** Drop `OUT_READY` for 5 cycles after the first valid. Required: head held at PC 0; `ADDRESS` stops advancing with ≤2 outstanding; after release, PCs 0,1,2,3 appear in order with no gaps or duplicates.
- **Redirect.** Assert `BRANCH_TAKEN` for one cycle with `BRANCH_TARGET`=3 mid-stream. Required: next `ADDRESS`=3; `OUT_VALID`=0 for 2 cycles; then `OUT_PC`=3, `OUT_INST`=0A080005; no stale PCs appear.
- **HALT.** Run from 0 with word 9 = 0F000000. Required: last valid is `OUT_PC`=9, `OUT_INST`=0F000000; `HALTED`=1 the cycle after it is accepted; `OUT_VALID` stays 0; `ADDRESS` is frozen. A subsequent redirect to 0 clears `HALTED` and restarts fetch.
- **Wrap.** Redirect to 1023 with `MEM_DEPTH`=1024. Required: `OUT_PC` sequence is 1023, 0, 1.
- **Async reset.** Pull `RESET_N` low between clock edges while 2 entries are buffered. Required: `OUT_VALID`, `OUT_INST`, `OUT_PC`, and `HALTED` go to 0 and `ADDRESS` goes to 0 without waiting for a clock edge; fetch resumes from PC 0.
